// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: alu_op codes, opcodes, FSM states
// and the instruction class produced by the decoder.
package alu_sequencer_pkg;

   typedef enum logic [5:0] {
      ALU_NOP  = 6'd0,
      ALU_LSL  = 6'd1,
      ALU_LSR  = 6'd2,
      ALU_STR  = 6'd3,
      ALU_LDR  = 6'd4,
      ALU_EMK  = 6'd5,
      ALU_ADD  = 6'd6,
      ALU_SUB  = 6'd7,
      ALU_AND  = 6'd8,
      ALU_ANDI = 6'd9,
      ALU_ORR  = 6'd10,
      ALU_ORRI = 6'd11,
      ALU_MOV  = 6'd12,
      ALU_MOVI = 6'd13,
      ALU_BEQ  = 6'd14
   } alu_op_t;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LSL  = 4'd1;
   localparam logic [3:0] OP_LSR  = 4'd2;
   localparam logic [3:0] OP_STR  = 4'd3;
   localparam logic [3:0] OP_LDR  = 4'd4;
   localparam logic [3:0] OP_EMK  = 4'd5;
   localparam logic [3:0] OP_ADD  = 4'd6;
   localparam logic [3:0] OP_SUB  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_ANDI = 4'd9;
   localparam logic [3:0] OP_ORR  = 4'd10;
   localparam logic [3:0] OP_ORRI = 4'd11;
   localparam logic [3:0] OP_MOV  = 4'd12;
   localparam logic [3:0] OP_MOVI = 4'd13;
   localparam logic [3:0] OP_BEQ  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALTED = 3'd5
   } seq_state_t;

   // Instructions with none of these bits set (NOP) simply advance the PC.
   typedef struct packed {
      logic is_mem;
      logic is_store;
      logic is_branch;
      logic is_halt;
      logic sets_flag;
      logic has_wb;
   } inst_class_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode to the shared alu_op code
// and the instruction class that steers the sequencer.
module alu_seq_decode
   import alu_sequencer_pkg::*;
(
   input  logic [3:0]  opcode,
   output alu_op_t     alu_op,
   output inst_class_t cls
);

   always_comb begin
      alu_op = ALU_NOP;
      cls    = '0;
      case (opcode)
         OP_NOP:  alu_op = ALU_NOP;
         OP_LSL:  begin alu_op = ALU_LSL;  cls.has_wb = 1'b1; end
         OP_LSR:  begin alu_op = ALU_LSR;  cls.has_wb = 1'b1; end
         OP_STR:  begin alu_op = ALU_STR;  cls.is_mem = 1'b1; cls.is_store = 1'b1; end
         OP_LDR:  begin alu_op = ALU_LDR;  cls.is_mem = 1'b1; end
         OP_EMK:  begin alu_op = ALU_EMK;  cls.has_wb = 1'b1; end
         OP_ADD:  begin alu_op = ALU_ADD;  cls.has_wb = 1'b1; cls.sets_flag = 1'b1; end
         OP_SUB:  begin alu_op = ALU_SUB;  cls.has_wb = 1'b1; cls.sets_flag = 1'b1; end
         OP_AND:  begin alu_op = ALU_AND;  cls.has_wb = 1'b1; end
         OP_ANDI: begin alu_op = ALU_ANDI; cls.has_wb = 1'b1; end
         OP_ORR:  begin alu_op = ALU_ORR;  cls.has_wb = 1'b1; end
         OP_ORRI: begin alu_op = ALU_ORRI; cls.has_wb = 1'b1; end
         OP_MOV:  begin alu_op = ALU_MOV;  cls.has_wb = 1'b1; end
         OP_MOVI: begin alu_op = ALU_MOVI; cls.has_wb = 1'b1; end
         OP_BEQ:  begin alu_op = ALU_BEQ;  cls.is_branch = 1'b1; end
         OP_HALT: begin alu_op = ALU_NOP;  cls.is_halt = 1'b1; end
         default: alu_op = ALU_NOP;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the 8-bit lab ALU.
// Optional performance counters are built when ALU_SEQ_PERF_CNT_EN is defined.
//
// Handshakes: inst_req_o / mem_req_o are held high from the cycle the request
// is raised until the cycle the matching *_ack_i is sampled high at a rising
// clock edge; the request drops on the cycle after that edge. An ack sampled
// while its request is low has no effect.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic [8:0]      inst_i,
   input  logic            inst_ack_i,
   input  logic            alu_zero_i,
   input  logic            alu_ov_i,
   input  logic            mem_ack_i,
   output logic [PC_W-1:0] pc_o,
   output logic            inst_req_o,
   output logic [8:0]      ir_o,
   output logic [5:0]      alu_op_o,
   output logic            alu_ov_o,
   output logic            rf_we_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic            done_o,
   output logic [15:0]     cyc_cnt_o,
   output logic [15:0]     ret_cnt_o,
   output seq_state_t      state_o
);

   seq_state_t      state, state_nx;
   logic [PC_W-1:0] pc, pc_nx;
   logic [8:0]      ir, ir_nx;
   logic            flag, flag_nx;
   logic            start_ok;
   logic [PC_W-1:0] pc_inc, pc_br;
   alu_op_t         dec_op;
   inst_class_t     dec_cls;

   // IR only changes on a fetch ack, so decoding ir_nx gives the current
   // instruction in EXEC/MEM and the incoming one on the way into EXEC.
   assign ir_nx = (state == S_FETCH && inst_ack_i) ? inst_i : ir;

   alu_seq_decode u_decode (
      .opcode (ir_nx[8:5]),
      .alu_op (dec_op),
      .cls    (dec_cls)
   );

   assign start_ok = start_i && (state == S_IDLE || state == S_HALTED);
   assign pc_inc   = pc + PC_W'(1);
   assign pc_br    = pc + PC_W'($signed(ir[4:0]));

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      flag_nx  = flag;
      case (state)
         S_IDLE, S_HALTED: begin
            if (start_ok) begin
               state_nx = S_FETCH;
               pc_nx    = START_PC;
               flag_nx  = 1'b0;
            end
         end
         S_FETCH: begin
            if (inst_ack_i) state_nx = S_EXEC;
         end
         S_EXEC: begin
            if (dec_cls.sets_flag) flag_nx = alu_ov_i;
            if (dec_cls.is_branch) begin
               pc_nx    = alu_zero_i ? pc_br : pc_inc;
               state_nx = S_FETCH;
            end else if (dec_cls.is_mem) begin
               state_nx = S_MEM;
            end else if (dec_cls.is_halt) begin
               state_nx = S_HALTED;
            end else if (dec_cls.has_wb) begin
               state_nx = S_WB;
            end else begin
               pc_nx    = pc_inc;
               state_nx = S_FETCH;
            end
         end
         S_MEM: begin
            if (mem_ack_i) begin
               if (dec_cls.is_store) begin
                  pc_nx    = pc_inc;
                  state_nx = S_FETCH;
               end else begin
                  state_nx = S_WB;
               end
            end
         end
         S_WB: begin
            pc_nx    = pc_inc;
            state_nx = S_FETCH;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         pc         <= START_PC;
         ir         <= '0;
         flag       <= 1'b0;
         inst_req_o <= 1'b0;
         rf_we_o    <= 1'b0;
         mem_req_o  <= 1'b0;
         mem_we_o   <= 1'b0;
         done_o     <= 1'b0;
         alu_op_o   <= ALU_NOP;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         ir         <= ir_nx;
         flag       <= flag_nx;
         inst_req_o <= (state_nx == S_FETCH);
         rf_we_o    <= (state_nx == S_WB);
         mem_req_o  <= (state_nx == S_MEM);
         mem_we_o   <= (state_nx == S_MEM) && dec_cls.is_store;
         done_o     <= (state_nx == S_HALTED);
         alu_op_o   <= (state_nx == S_EXEC || state_nx == S_MEM) ? dec_op : ALU_NOP;
      end
   end

   assign pc_o     = pc;
   assign ir_o     = ir;
   assign alu_ov_o = flag;
   assign state_o  = state;

`ifdef ALU_SEQ_PERF_CNT_EN
   logic active, retire;
   logic [15:0] cyc_cnt, ret_cnt;

   assign active = (state != S_IDLE) && (state != S_HALTED);
   assign retire = (state == S_WB)
                || (state == S_MEM && mem_ack_i && dec_cls.is_store)
                || (state == S_EXEC && !dec_cls.is_mem && !dec_cls.has_wb);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
      end else if (start_ok) begin
         cyc_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (active && cyc_cnt != 16'hFFFF) cyc_cnt <= cyc_cnt + 16'd1;
         if (retire && ret_cnt != 16'hFFFF) ret_cnt <= ret_cnt + 16'd1;
      end
   end

   assign cyc_cnt_o = cyc_cnt;
   assign ret_cnt_o = ret_cnt;
`else
   assign cyc_cnt_o = 16'd0;
   assign ret_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer: an instruction-level model
// predicts the event stream (fetch, exec, mem, writeback, halt) per instruction.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   localparam int EW = 19;
   localparam logic [2:0] K_F = 3'd1, K_E = 3'd2, K_M = 3'd3, K_W = 3'd4, K_H = 3'd5;

   logic        clk, reset, start_i, inst_ack_i, alu_zero_i, alu_ov_i, mem_ack_i;
   logic [8:0]  inst_i, ir_o;
   logic [7:0]  pc_o;
   logic [5:0]  alu_op_o;
   logic        inst_req_o, alu_ov_o, rf_we_o, mem_req_o, mem_we_o, done_o;
   logic [15:0] cyc_cnt_o, ret_cnt_o;
   seq_state_t  state_o;

   logic [EW-1:0] exp_q[$];
   int          n_vec, n_err;
   int          mem_delay;
   bit          spur_en;
   logic [7:0]  m_pc;
   logic        m_flag;

   alu_sequencer #(.PC_W(8), .START_PC(8'h00)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .inst_i(inst_i),
      .inst_ack_i(inst_ack_i), .alu_zero_i(alu_zero_i), .alu_ov_i(alu_ov_i),
      .mem_ack_i(mem_ack_i), .pc_o(pc_o), .inst_req_o(inst_req_o), .ir_o(ir_o),
      .alu_op_o(alu_op_o), .alu_ov_o(alu_ov_o), .rf_we_o(rf_we_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .done_o(done_o),
      .cyc_cnt_o(cyc_cnt_o), .ret_cnt_o(ret_cnt_o), .state_o(state_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   function automatic logic [EW-1:0] ev(input logic [2:0] k, input logic [7:0] p,
                                        input logic f, input logic w, input logic [5:0] a);
      return {k, p, f, w, a};
   endfunction

   task automatic sb_pop(input string name, input logic [EW-1:0] act);
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: unexpected event actual=%0h expected=none", name, act);
      end else begin
         chk(name, 32'(act), 32'(exp_q.pop_front()));
      end
   endtask

   // Opcode table of the instruction set.
   function automatic logic [5:0] ref_alu_op(input logic [3:0] opc);
      case (opc)
         4'd1:  return ALU_LSL;
         4'd2:  return ALU_LSR;
         4'd3:  return ALU_STR;
         4'd4:  return ALU_LDR;
         4'd5:  return ALU_EMK;
         4'd6:  return ALU_ADD;
         4'd7:  return ALU_SUB;
         4'd8:  return ALU_AND;
         4'd9:  return ALU_ANDI;
         4'd10: return ALU_ORR;
         4'd11: return ALU_ORRI;
         4'd12: return ALU_MOV;
         4'd13: return ALU_MOVI;
         4'd14: return ALU_BEQ;
         default: return ALU_NOP;
      endcase
   endfunction

   // ---------------- reference model ----------------
   task automatic model_restart();
      m_pc   = 8'h00;
      m_flag = 1'b0;
   endtask

   task automatic model_issue(input logic [8:0] inst, input logic z, input logic ov);
      int         opc, off, npc;
      logic [5:0] aop;
      logic       nf;
      opc = int'(inst[8:5]);
      aop = ref_alu_op(inst[8:5]);
      nf  = m_flag;
      if (opc == 6 || opc == 7) nf = ov;
      exp_q.push_back(ev(K_F, m_pc, m_flag, 1'b0, 6'd0));
      exp_q.push_back(ev(K_E, m_pc, m_flag, 1'b0, aop));
      npc = (int'(m_pc) + 1) % 256;
      case (opc)
         0: ;
         3: exp_q.push_back(ev(K_M, m_pc, nf, 1'b1, aop));
         4: begin
            exp_q.push_back(ev(K_M, m_pc, nf, 1'b0, aop));
            exp_q.push_back(ev(K_W, m_pc, nf, 1'b0, 6'd0));
         end
         14: begin
            off = int'(inst[4:0]);
            if (off >= 16) off = off - 32;
            if (z) npc = (int'(m_pc) + off + 256) % 256;
         end
         15: begin
            exp_q.push_back(ev(K_H, m_pc, nf, 1'b0, 6'd0));
            npc = int'(m_pc);
         end
         default: exp_q.push_back(ev(K_W, m_pc, nf, 1'b0, 6'd0));
      endcase
      m_pc   = 8'(npc);
      m_flag = nf;
   endtask

   // ---------------- drivers (called at posedge+1) ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int t = 0;
      while (!inst_req_o && t < 100) begin
         sync();
         t++;
      end
      if (!inst_req_o) chk("inst_req_timeout", 32'(inst_req_o), 32'd1);
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done_o && t < 100) begin
         sync();
         t++;
      end
      if (!done_o) chk("done_timeout", 32'(done_o), 32'd1);
   endtask

   task automatic do_start();
      start_i = 1'b1;
      sync();
      start_i = 1'b0;
      model_restart();
   endtask

   task automatic issue_inst(input logic [8:0] inst, input logic z, input logic ov,
                             input int dly, input bit spur);
      wait_req();
      if (!inst_req_o) return;
      for (int i = 0; i < dly; i++) begin
         if (spur && i == 0) start_i = 1'b1;
         sync();
         start_i = 1'b0;
      end
      inst_i     = inst;
      inst_ack_i = 1'b1;
      alu_zero_i = z;
      alu_ov_i   = ov;
      model_issue(inst, z, ov);
      sync();
      inst_ack_i = 1'b0;
      inst_i     = 9'($urandom);
   endtask

   // ---------------- data memory responder ----------------
   initial begin
      int  cnt;
      bit  busy;
      mem_ack_i = 1'b0;
      busy = 1'b0;
      cnt  = 0;
      forever begin
         sync();
         if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            busy = 1'b0;
         end else if (mem_req_o) begin
            if (!busy) begin
               busy = 1'b1;
               cnt  = mem_delay;
            end
            if (cnt == 0) mem_ack_i = 1'b1;
            else cnt--;
         end else begin
            busy = 1'b0;
            if (spur_en && $urandom_range(0, 9) == 0) mem_ack_i = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      logic done_q;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            done_q = 1'b0;
         end else begin
            if (inst_req_o && inst_ack_i)
               sb_pop("fetch", ev(K_F, pc_o, alu_ov_o, mem_we_o, 6'd0));
            if (state_o == S_EXEC)
               sb_pop("exec", ev(K_E, pc_o, alu_ov_o, mem_we_o, alu_op_o));
            if (mem_req_o && mem_ack_i)
               sb_pop("mem", ev(K_M, pc_o, alu_ov_o, mem_we_o, alu_op_o));
            if (rf_we_o)
               sb_pop("wb", ev(K_W, pc_o, alu_ov_o, mem_we_o, 6'd0));
            if (done_o && !done_q)
               sb_pop("halt", ev(K_H, pc_o, alu_ov_o, mem_we_o, 6'd0));
            done_q = done_o;
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [8:0] r_inst;
      int         n_req, t;
      bit         saw_we;
      n_vec = 0; n_err = 0;
      reset = 1'b1; start_i = 1'b0; inst_i = '0; inst_ack_i = 1'b0;
      alu_zero_i = 1'b0; alu_ov_i = 1'b0; mem_delay = 0; spur_en = 1'b0;
      model_restart();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", 32'(state_o), 32'(S_IDLE));
      chk("rst_pc", 32'(pc_o), 32'h0);
      chk("rst_ir", 32'(ir_o), 32'h0);
      chk("rst_alu_op", 32'(alu_op_o), 32'(ALU_NOP));
      chk("rst_outs", 32'({inst_req_o, alu_ov_o, rf_we_o, mem_req_o, mem_we_o, done_o}), 32'h0);
      chk("rst_cnts", 32'({cyc_cnt_o, ret_cnt_o}), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_hold", 32'(state_o), 32'(S_IDLE));
      sync();

      // ADD with carry out, zero-wait
      do_start();
      issue_inst(9'b0110_00000, 1'b0, 1'b1, 0, 0);
      @(negedge clk);
      chk("add_no_we_c2", 32'(rf_we_o), 32'd0);
      @(negedge clk);
      chk("add_we_c3", 32'(rf_we_o), 32'd1);
      chk("add_ov_c3", 32'(alu_ov_o), 32'd1);
      sync();

      // BEQ backward across zero, taken then not taken
      issue_inst(9'b0000_00000, 1'b0, 1'b0, 0, 0);
      issue_inst(9'b1110_11100, 1'b1, 1'b0, 0, 0);
      wait_req();
      chk("beq_taken_pc", 32'(pc_o), 32'd254);
      issue_inst(9'b1111_00000, 1'b0, 1'b0, 0, 0);
      wait_done();
      do_start();
      issue_inst(9'b0000_00000, 1'b0, 1'b0, 0, 0);
      issue_inst(9'b0000_00000, 1'b0, 1'b0, 0, 0);
      issue_inst(9'b1110_11100, 1'b0, 1'b0, 0, 0);
      wait_req();
      chk("beq_nt_pc", 32'(pc_o), 32'd3);

      // LDR with a 3-cycle memory wait
      mem_delay = 3;
      issue_inst(9'b0100_00011, 1'b0, 1'b0, 0, 0);
      n_req = 0; saw_we = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (mem_req_o) n_req++;
         if (mem_we_o) saw_we = 1'b1;
         if (rf_we_o) break;
      end
      chk("ldr_req_cycles", 32'(n_req), 32'd4);
      chk("ldr_mem_we", 32'(saw_we), 32'd0);
      mem_delay = 0;
      sync();

      // HALT at pc 7, with a start pulse during a FETCH wait on the way
      issue_inst(9'b0000_00000, 1'b0, 1'b0, 0, 0);
      issue_inst(9'b0000_00000, 1'b0, 1'b0, 2, 1);
      issue_inst(9'b0000_00000, 1'b0, 1'b0, 0, 0);
      issue_inst(9'b1111_00000, 1'b0, 1'b0, 0, 0);
      wait_done();
      repeat (3) sync();
      chk("halt_done", 32'(done_o), 32'd1);
      chk("halt_pc", 32'(pc_o), 32'd7);
      do_start();
      chk("restart_pc", 32'(pc_o), 32'd0);

      // randomized program
      spur_en = 1'b1;
      for (int n = 0; n < 300; n++) begin
         r_inst = 9'($urandom);
         mem_delay = $urandom_range(0, 3);
         issue_inst(r_inst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
         if (r_inst[8:5] == OP_HALT) begin
            wait_done();
            repeat ($urandom_range(0, 3)) sync();
            do_start();
         end
      end
      spur_en = 1'b0;
      repeat (8) sync();

      // asynchronous reset while a load waits on memory
      mem_delay = 20;
      issue_inst(9'b0100_00000, 1'b0, 1'b0, 0, 0);
      t = 0;
      while (!mem_req_o && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("rst_mid_pre_req", 32'(mem_req_o), 32'd1);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_mid_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_mid_state", 32'(state_o), 32'(S_IDLE));
      chk("rst_mid_pc", 32'(pc_o), 32'd0);
      sync();
      reset = 1'b0;
      model_restart();
      mem_delay = 0;
      sync();

      // NOP, ADD, HALT at zero wait for the performance counters
      do_start();
      issue_inst(9'b0000_00000, 1'b0, 1'b0, 0, 0);
      issue_inst(9'b0110_00001, 1'b0, 1'b0, 0, 0);
      issue_inst(9'b1111_00000, 1'b0, 1'b0, 0, 0);
      wait_done();
`ifdef ALU_SEQ_PERF_CNT_EN
      chk("perf_ret", 32'(ret_cnt_o), 32'd3);
      chk("perf_cyc", 32'(cyc_cnt_o), 32'd7);
      repeat (3) sync();
      chk("perf_hold", 32'({cyc_cnt_o, ret_cnt_o}), {16'd7, 16'd3});
`else
      chk("perf_ret_off", 32'(ret_cnt_o), 32'd0);
      chk("perf_cyc_off", 32'(cyc_cnt_o), 32'd0);
`endif

      repeat (4) sync();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
